// File: rtl/spi_xfer_arbiter.sv
// ============================================================================
// spi_xfer_arbiter
//   Round-robin sharing of one byte-wide SPI engine among NREQ requesters.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module spi_xfer_arbiter #(
  parameter int NREQ = 4,
  parameter int MAXB = 4,
  parameter int GAP  = 2,
  parameter int WDOG = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [3*NREQ-1:0]      req_len,
  input  logic [8*MAXB*NREQ-1:0] req_tx,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   err,
  output logic [8*MAXB-1:0]      rx_word,
  output logic                   eng_start,
  output logic [7:0]             eng_tx_data,
  input  logic                   eng_busy,
  input  logic [7:0]             eng_rx_data
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RXW = 8 * MAXB;
  localparam int WW  = $clog2(WDOG + 1) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;
  localparam logic [2:0] S_POST    = 3'd6;

  logic [2:0]     r_state;
  logic [IW-1:0]  r_last;
  logic [2:0]     r_len;
  logic [2:0]     r_k;
  logic [RXW-1:0] r_tx;
  logic [RXW-1:0] r_rxsr;
  logic [3:0]     r_gap;
  logic [WW-1:0]  r_wd;

  logic           w_found;
  logic [IW-1:0]  w_win;
  logic [2:0]     w_len_raw;
  logic [2:0]     w_len;
  logic [RXW-1:0] w_tx;
  logic [2:0]     w_sel;
  logic [RXW-1:0] w_tx_shift;
  logic [7:0]     w_byte;
  logic [RXW-1:0] w_rx_shift;

  // Search begins just past the last winner and wraps around.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = r_last;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(r_last) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = IW'(idx);
      end
    end
  end

  always_comb begin
    w_len_raw = req_len[3*int'(w_win) +: 3];
    if (w_len_raw == 3'd0)
      w_len = 3'd1;
    else if (w_len_raw > 3'(MAXB))
      w_len = 3'(MAXB);
    else
      w_len = w_len_raw;
    w_tx = req_tx[RXW*int'(w_win) +: RXW];
  end

  // Most significant used byte goes out first.
  always_comb begin
    w_sel      = r_len - r_k - 3'd1;
    w_tx_shift = r_tx >> {w_sel, 3'b000};
    w_byte     = w_tx_shift[7:0];
    w_rx_shift = (r_rxsr << 8) | RXW'(eng_rx_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= IW'(NREQ - 1);
      r_len       <= 3'd1;
      r_k         <= 3'd0;
      r_tx        <= '0;
      r_rxsr      <= '0;
      r_gap       <= 4'd0;
      r_wd        <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      rx_word     <= '0;
      eng_start   <= 1'b0;
      eng_tx_data <= 8'h00;
    end else begin
      eng_start <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            gnt     <= NREQ'(1) << w_win;
            r_last  <= w_win;
            r_len   <= w_len;
            r_tx    <= w_tx;
            r_rxsr  <= '0;
            r_k     <= 3'd0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!eng_busy) begin
            eng_start   <= 1'b1;
            eng_tx_data <= w_byte;
            r_wd        <= '0;
            r_state     <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (eng_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_wd == WW'(WDOG - 1)) begin
            done    <= gnt;
            err     <= 1'b1;
            rx_word <= r_rxsr;
            gnt     <= '0;
            r_state <= S_RESP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!eng_busy) begin
            r_rxsr <= w_rx_shift;
            r_k    <= r_k + 3'd1;
            if (r_k + 3'd1 == r_len) begin
              // Outputs are set on entry so done is visible during RESP.
              done    <= gnt;
              rx_word <= w_rx_shift;
              gnt     <= '0;
              r_state <= S_RESP;
            end else if (GAP == 0) begin
              r_state <= S_ISSUE;
            end else begin
              r_gap   <= 4'd0;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == 4'(GAP - 1))
            r_state <= S_ISSUE;
          else
            r_gap <= r_gap + 4'd1;
        end
        S_RESP: begin
          if (GAP == 0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap   <= 4'd0;
            r_state <= S_POST;
          end
        end
        S_POST: begin
          if (r_gap == 4'(GAP - 1))
            r_state <= S_IDLE;
          else
            r_gap <= r_gap + 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Sequences and shares the single byte-wide SPI master engine among NREQ requesters.
- Each requester posts a 1..MAXB-byte transaction. The block grants requesters round-robin and feeds the bytes to the engine one at a time using the engine's start/busy handshake.
- It assembles the received bytes into one word and returns it with a one-cycle done pulse.
- It sits between client logic (register bridge, flash loader, sensor poller) and the SPI byte engine.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAXB, 4, maximum bytes per transaction (1..7).
- GAP, 2, idle cycles inserted between consecutive bytes and after each transaction (0..15).
- WDOG, 3, cycles allowed after eng_start for eng_busy to rise before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester request level.
- req_len  in  3*NREQ  byte count for requester i, at bits [3i+2:3i]. Value 0 is treated as 1; values >MAXB are clamped to MAXB.
- req_tx  in  8*MAXB*NREQ  transmit word for requester i, at slice [8*MAXB*(i+1)-1 : 8*MAXB*i].
- gnt  out  NREQ  one-hot grant, held for the whole transaction.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done when the watchdog aborts.
- rx_word  out  8*MAXB  received data, valid in the done cycle and held until the next done.
- eng_start  out  1  one-cycle start pulse to the SPI byte engine.
- eng_tx_data  out  8  byte to transmit. Stable from eng_start until eng_busy falls.
- eng_busy  in  1  engine busy.
- eng_rx_data  in  8  engine received byte, valid in the first cycle eng_busy is low after being high.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): gnt=0, done=0, err=0, rx_word=0, eng_start=0, eng_tx_data=0. State goes to IDLE. The round-robin pointer is set to NREQ-1, so requester 0 wins first.
  - Reset mid-transaction abandons it: no done is issued and eng_start is forced low.
- Arbitration happens only in IDLE.
  - Search starts at (last_grant+1) mod NREQ and wraps; the first requester with req=1 wins.
  - Winner is registered into gnt. The latched length L (after the 0 and >MAXB rules) and tx word are captured the same cycle.
  - last_grant updates to the winner.
- State machine:
  - IDLE: if any req, grant, clear the rx shift register and byte count k=0, go ISSUE.
  - ISSUE: requires eng_busy=0. Drive eng_start=1 for exactly one cycle and eng_tx_data = byte k, then go WAIT_HI. Byte k is latched tx bits [8(L-k)-1 : 8(L-k)-8], i.e. the most significant used byte goes first.
  - WAIT_HI: wait for eng_busy=1, then go WAIT_LO. If WDOG cycles pass without busy, go RESP with the abort flag set.
  - WAIT_LO: on the first cycle with eng_busy=0, shift eng_rx_data in: rxsr <= {rxsr[8*MAXB-9:0], eng_rx_data}. Then k++. If k==L go RESP, else go GAP.
  - GAP: count GAP cycles (0 means skip the state), then go ISSUE.
  - RESP: one cycle.
    - done[winner]=1; err=abort; rx_word <= rxsr. Upper unused bytes are zero.
    - Drop gnt. Wait GAP cycles, then go IDLE.
- The requester must hold req_len and req_tx stable while granted. req dropping while granted is ignored and the transaction completes.
- A requester still asserting req after its done re-competes only after the post-transaction gap, so it is not granted in the done cycle.
- Latency for L bytes with the standard engine: about 1 + L*(2+16+1) + (L-1)*GAP + 1 + GAP cycles. This is not required exactly. The bench checks ordering, not absolute counts.
- Only one eng_start may be asserted per byte. eng_start must never be asserted while eng_busy=1.

Test Plan:
- Single requester 0: len=1, tx=0x000000A5; slave returns 0x3C. Required: one eng_start with eng_tx_data=0xA5; done=0001; rx_word=0x0000003C; err=0.
- Requester 2: len=3, tx=0x00112233; slave returns 0xAA, 0xBB, 0xCC. Required: bytes sent in order 0x11, 0x22, 0x33; at least GAP idle cycles between eng_busy falling and the next eng_start; rx_word=0x00AABBCC.
- All four req held high with len=1. Required: grant order 0,1,2,3,0,1; no requester is granted twice before the others are served.
- Edge lengths: len=0 sends exactly 1 byte; len=7 with MAXB=4 sends 4 bytes, starting with tx[31:24].
- Watchdog: engine model never raises busy. Required: done to the granted requester with err=1 after WDOG cycles; the next request still proceeds normally.
- Reset mid-transaction: assert rst while in WAIT_LO of byte 2 of 3. Required: the next cycle gnt=0, eng_start=0, no done pulse. After release, requester 0 is granted first.
